// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART line receiver and its pin-side checkers.
// Holds the FSM state encoding, the frame-length encoding and the bit-count decode.
package uart_rx_pkg;

    localparam int UART_MAX_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        BITS_5 = 2'b00,
        BITS_6 = 2'b01,
        BITS_7 = 2'b10,
        BITS_8 = 2'b11
    } cfg_bits_e;

    function automatic logic [3:0] bits_to_count(input logic [1:0] bits);
        logic [3:0] count;
        count = 4'd8;
        case (cfg_bits_e'(bits))
            BITS_5:  count = 4'd5;
            BITS_6:  count = 4'd6;
            BITS_7:  count = 4'd7;
            BITS_8:  count = 4'd8;
            default: count = 4'd8;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for idle-high asynchronous lines; every stage resets to 1
// so a line that idles high produces no spurious falling edge after reset.
module uart_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic r_meta;
            logic r_sync;

            always_ff @(posedge i_clk) begin
                if (!i_rstn) begin
                    r_meta <= 1'b1;
                    r_sync <= 1'b1;
                end else begin
                    r_meta <= i_d[gi];
                    r_sync <= r_meta;
                end
            end

            assign o_q[gi] = r_sync;
        end
    endgenerate

endmodule

// File: rtl/uart_serial_rx.sv
// UART line receiver: oversampled start/data/parity/stop decoding with a
// one-entry valid/ready output buffer and single-cycle error pulses.
module uart_serial_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             sys_clk_i,
    input  logic             rstn_i,
    input  logic             cfg_en_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_bits_i,
    input  logic             cfg_parity_en_i,
    input  logic             cfg_stop_bits_i,
    input  logic             uart_line_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             err_parity_o,
    output logic             err_frame_o,
    output logic             err_overflow_o,
    output logic             busy_o
);

    logic             w_line;
    logic             w_fall;
    logic             w_cnt_zero;
    logic             w_frame_bad;

    logic             r_line_prev;
    rx_state_e        r_state,     w_state_next;
    logic [DIV_W-1:0] r_cnt,       w_cnt_next;
    logic [DIV_W-1:0] r_div,       w_div_next;
    logic [3:0]       r_nbits,     w_nbits_next;
    logic             r_par_en,    w_par_en_next;
    logic             r_stop2,     w_stop2_next;
    logic [3:0]       r_bit_idx,   w_bit_idx_next;
    logic             r_stop_idx,  w_stop_idx_next;
    logic [UART_MAX_BITS-1:0] r_shift, w_shift_next;
    logic             r_par_err,   w_par_err_next;
    logic             r_frm_err,   w_frm_err_next;
    logic [7:0]       r_data,      w_data_next;
    logic             r_valid,     w_valid_next;
    logic             r_err_par,   w_err_par_next;
    logic             r_err_frm,   w_err_frm_next;
    logic             r_err_ovf,   w_err_ovf_next;

    uart_sync_2ff #(
        .WIDTH (1)
    ) u_line_sync (
        .i_clk  (sys_clk_i),
        .i_rstn (rstn_i),
        .i_d    (uart_line_i),
        .o_q    (w_line)
    );

    assign w_fall     = r_line_prev & ~w_line;
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge sys_clk_i) begin
        if (!rstn_i) begin
            r_line_prev <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_div       <= '0;
            r_nbits     <= 4'd8;
            r_par_en    <= 1'b0;
            r_stop2     <= 1'b0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_err_par   <= 1'b0;
            r_err_frm   <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_line_prev <= w_line;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_div       <= w_div_next;
            r_nbits     <= w_nbits_next;
            r_par_en    <= w_par_en_next;
            r_stop2     <= w_stop2_next;
            r_bit_idx   <= w_bit_idx_next;
            r_stop_idx  <= w_stop_idx_next;
            r_shift     <= w_shift_next;
            r_par_err   <= w_par_err_next;
            r_frm_err   <= w_frm_err_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_err_par   <= w_err_par_next;
            r_err_frm   <= w_err_frm_next;
            r_err_ovf   <= w_err_ovf_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_div_next      = r_div;
        w_nbits_next    = r_nbits;
        w_par_en_next   = r_par_en;
        w_stop2_next    = r_stop2;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_shift_next    = r_shift;
        w_par_err_next  = r_par_err;
        w_frm_err_next  = r_frm_err;
        w_data_next     = r_data;
        w_valid_next    = r_valid & ~rx_ready_i;
        w_err_par_next  = 1'b0;
        w_err_frm_next  = 1'b0;
        w_err_ovf_next  = 1'b0;
        w_frame_bad     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cfg_en_i && w_fall) begin
                    w_div_next      = cfg_div_i;
                    w_nbits_next    = bits_to_count(cfg_bits_i);
                    w_par_en_next   = cfg_parity_en_i;
                    w_stop2_next    = cfg_stop_bits_i;
                    w_cnt_next      = cfg_div_i >> 1;
                    w_bit_idx_next  = '0;
                    w_stop_idx_next = 1'b0;
                    w_shift_next    = '0;
                    w_par_err_next  = 1'b0;
                    w_frm_err_next  = 1'b0;
                    w_state_next    = ST_START;
                end
            end

            ST_START: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - DIV_W'(1);
                end else if (w_line) begin
                    // Line already back high at mid-start: treat as a glitch.
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next   = r_div;
                    w_state_next = ST_DATA;
                end
            end

            ST_DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - DIV_W'(1);
                end else begin
                    w_shift_next[r_bit_idx[2:0]] = w_line;
                    w_cnt_next = r_div;
                    if (r_bit_idx == (r_nbits - 4'd1)) begin
                        w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 4'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - DIV_W'(1);
                end else begin
                    // Unused upper shift bits are zero, so a full-width XOR is exact.
                    w_par_err_next = (^r_shift) ^ w_line;
                    w_cnt_next     = r_div;
                    w_state_next   = ST_STOP;
                end
            end

            ST_STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - DIV_W'(1);
                end else begin
                    w_frame_bad = r_frm_err | ~w_line;
                    if (r_stop2 && !r_stop_idx) begin
                        w_stop_idx_next = 1'b1;
                        w_frm_err_next  = w_frame_bad;
                        w_cnt_next      = r_div;
                    end else begin
                        w_state_next = ST_IDLE;
                        if (w_frame_bad) begin
                            w_err_frm_next = 1'b1;
                        end else begin
                            w_err_par_next = r_par_err;
                            if (!r_valid || rx_ready_i) begin
                                w_data_next  = r_shift;
                                w_valid_next = 1'b1;
                            end else begin
                                w_err_ovf_next = 1'b1;
                            end
                        end
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Disable aborts the frame silently but leaves the output buffer alone.
        if (!cfg_en_i) begin
            w_state_next   = ST_IDLE;
            w_cnt_next     = '0;
            w_shift_next   = '0;
            w_data_next    = r_data;
            w_valid_next   = r_valid & ~rx_ready_i;
            w_err_par_next = 1'b0;
            w_err_frm_next = 1'b0;
            w_err_ovf_next = 1'b0;
        end
    end

    assign rx_data_o      = r_data;
    assign rx_valid_o     = r_valid;
    assign err_parity_o   = r_err_par;
    assign err_frame_o    = r_err_frm;
    assign err_overflow_o = r_err_ovf;
    assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_serial_rx.sv
// Self-checking bench for uart_serial_rx: table-driven frames with exact timing,
// hand-written corner sequences, and randomized frames against a frame-level model.
module tb_uart_serial_rx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b1;
    logic [15:0] div = 16'd15;
    logic [1:0]  bits = 2'b11;
    logic        pe = 1'b0;
    logic        s2 = 1'b0;
    logic        line = 1'b1;
    logic        ready = 1'b0;

    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        err_parity_o;
    logic        err_frame_o;
    logic        err_overflow_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_ovf  = 0;
    logic [7:0] got[$];

    uart_serial_rx #(
        .DIV_W (16)
    ) dut (
        .sys_clk_i       (clk),
        .rstn_i          (rstn),
        .cfg_en_i        (en),
        .cfg_div_i       (div),
        .cfg_bits_i      (bits),
        .cfg_parity_en_i (pe),
        .cfg_stop_bits_i (s2),
        .uart_line_i     (line),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (ready),
        .err_parity_o    (err_parity_o),
        .err_frame_o     (err_frame_o),
        .err_overflow_o  (err_overflow_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_parity_o)   n_perr++;
        if (err_frame_o)    n_ferr++;
        if (err_overflow_o) n_ovf++;
        if (rx_valid_o && ready) got.push_back(rx_data_o);
    end

    typedef struct {
        int         div;
        logic [1:0] bits;
        bit         pe;
        bit         s2;
        logic [7:0] data;
        bit         flip;
        bit         stop_low;
        logic [7:0] exp_data;
        bit         exp_valid;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Serialises one frame, one bit per p clocks, starting just after the current edge.
    task automatic drive(input logic [7:0] d, input int n, input bit par_en, input bit stop2,
                         input int p, input bit flip, input bit stop_low);
        logic       fbits[$];
        logic [7:0] m;
        logic [7:0] md;
        m  = 8'hFF >> (8 - n);
        md = d & m;
        fbits.push_back(1'b0);
        for (int i = 0; i < n; i++) fbits.push_back(md[i]);
        if (par_en) fbits.push_back((^md) ^ flip);
        fbits.push_back(1'b1);
        if (stop2) fbits.push_back(1'b1);
        if (stop_low) fbits[fbits.size()-1] = 1'b0;
        for (int i = 0; i < fbits.size(); i++) begin
            #1 line = fbits[i];
            repeat (p) @(posedge clk);
        end
    endtask

    task automatic run_vector(input vec_t v, input bit drain);
        int p, h, f, k, n;
        @(negedge clk);
        div = 16'(v.div); bits = v.bits; pe = v.pe; s2 = v.s2; ready = 1'b0;
        n = 5 + int'(v.bits);
        p = v.div + 1;
        h = v.div >> 1;
        f = 2 + n + int'(v.pe) + int'(v.s2);
        k = 4 + h + (f - 1) * p;
        @(posedge clk);
        fork
            drive(v.data, n, v.pe, v.s2, p, v.flip, v.stop_low);
            begin
                repeat (k - 1) @(posedge clk);
                @(negedge clk);
                chk("busy_before_done", busy_o, 1);
                chk("valid_before_done", rx_valid_o, 0);
                @(posedge clk);
                @(negedge clk);
                chk("valid_done", rx_valid_o, v.exp_valid);
                if (v.exp_valid) chk("data_done", rx_data_o, v.exp_data);
                chk("perr_done", err_parity_o, v.exp_perr);
                chk("ferr_done", err_frame_o, v.exp_ferr);
                chk("ovf_done", err_overflow_o, 0);
                chk("busy_done", busy_o, 0);
                @(posedge clk);
                @(negedge clk);
                chk("perr_width", err_parity_o, 0);
                chk("ferr_width", err_frame_o, 0);
            end
        join
        #1 line = 1'b1;
        $display("tx div=%0d n=%0d par=%0d stop2=%0d data=%02h -> valid=%0d data=%02h",
                 v.div, n, v.pe, v.s2, v.data, rx_valid_o, rx_data_o);
        if (drain) begin
            @(negedge clk); ready = 1'b1;
            @(negedge clk); ready = 1'b0;
            chk("drained", rx_valid_o, 0);
        end
    endtask

    vec_t vecs[9];
    vec_t v3c;
    vec_t v5a;
    int   p0, f0, o0;

    initial begin
        vecs[0] = '{15, 2'b11, 0, 0, 8'hA5, 0, 0, 8'hA5, 1, 0, 0};
        vecs[1] = '{ 7, 2'b00, 1, 1, 8'h13, 0, 0, 8'h13, 1, 0, 0};
        vecs[2] = '{ 7, 2'b00, 1, 1, 8'h13, 1, 0, 8'h13, 1, 1, 0};
        vecs[3] = '{15, 2'b11, 0, 0, 8'h5A, 0, 1, 8'h00, 0, 0, 1};
        vecs[4] = '{ 3, 2'b10, 0, 0, 8'hFF, 0, 0, 8'h7F, 1, 0, 0};
        vecs[5] = '{ 4, 2'b01, 1, 0, 8'h2A, 0, 0, 8'h2A, 1, 0, 0};
        vecs[6] = '{ 9, 2'b00, 0, 1, 8'h15, 0, 1, 8'h00, 0, 0, 1};
        vecs[7] = '{ 5, 2'b11, 1, 0, 8'h00, 1, 0, 8'h00, 1, 1, 0};
        vecs[8] = '{ 6, 2'b11, 1, 1, 8'hC3, 1, 1, 8'h00, 0, 0, 1};
        v3c     = '{15, 2'b11, 0, 0, 8'h3C, 0, 0, 8'h3C, 1, 0, 0};
        v5a     = '{ 5, 2'b11, 0, 0, 8'h5A, 0, 0, 8'h5A, 1, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", rx_data_o, 0);
        chk("rst_valid", rx_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_perr", err_parity_o, 0);
        chk("rst_ferr", err_frame_o, 0);
        chk("rst_ovf", err_overflow_o, 0);
        rstn = 1'b1;
        repeat (4) @(posedge clk);

        foreach (vecs[i]) run_vector(vecs[i], 1'b1);

        // Glitch: 2-clock low pulse at P=16
        @(negedge clk);
        div = 16'd15; bits = 2'b11; pe = 1'b0; s2 = 1'b0;
        p0 = n_perr; f0 = n_ferr;
        @(posedge clk);
        #1 line = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 line = 1'b1;
        @(negedge clk);
        chk("glitch_busy_d", busy_o, 0);
        @(posedge clk); @(negedge clk);
        chk("glitch_busy_rise", busy_o, 1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_sample", busy_o, 1);
        @(posedge clk); @(negedge clk);
        chk("glitch_busy_fall", busy_o, 0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("glitch_valid", rx_valid_o, 0);
        chk("glitch_perr", n_perr - p0, 0);
        chk("glitch_ferr", n_ferr - f0, 0);
        $display("tx glitch busy=%0d valid=%0d", busy_o, rx_valid_o);

        // Overflow: two back-to-back frames into a full buffer
        o0 = n_ovf;
        ready = 1'b0;
        @(posedge clk);
        fork
            begin
                drive(8'h11, 8, 0, 0, 16, 0, 0);
                drive(8'h22, 8, 0, 0, 16, 0, 0);
            end
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                chk("ovf_first_valid", rx_valid_o, 1);
                chk("ovf_first_data", rx_data_o, 8'h11);
                repeat (160) @(posedge clk);
                @(negedge clk);
                chk("ovf_kept_data", rx_data_o, 8'h11);
                chk("ovf_kept_valid", rx_valid_o, 1);
                chk("ovf_pulse", err_overflow_o, 1);
            end
        join
        $display("tx overflow data=%02h valid=%0d", rx_data_o, rx_valid_o);
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        chk("ovf_drained", rx_valid_o, 0);

        // Same, but drained in the completion cycle of the second frame
        @(posedge clk);
        fork
            begin
                drive(8'h11, 8, 0, 0, 16, 0, 0);
                drive(8'h22, 8, 0, 0, 16, 0, 0);
            end
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                chk("sim_first_data", rx_data_o, 8'h11);
                repeat (159) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("sim_valid", rx_valid_o, 1);
                chk("sim_data", rx_data_o, 8'h22);
                chk("sim_no_ovf", err_overflow_o, 0);
                ready = 1'b0;
            end
        join
        chk("ovf_count", n_ovf - o0, 1);
        $display("tx drain+load data=%02h valid=%0d", rx_data_o, rx_valid_o);

        // Reset mid-frame with a byte still buffered
        @(posedge clk);
        fork
            drive(8'h77, 8, 0, 0, 16, 0, 0);
            begin
                repeat (50) @(posedge clk);
                #1 rstn = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("mrst_data", rx_data_o, 0);
                chk("mrst_valid", rx_valid_o, 0);
                chk("mrst_busy", busy_o, 0);
                chk("mrst_errs", {err_parity_o, err_frame_o, err_overflow_o}, 0);
            end
        join
        @(negedge clk); rstn = 1'b1;
        repeat (4) @(posedge clk);
        $display("tx reset mid-frame valid=%0d", rx_valid_o);
        run_vector(v3c, 1'b1);

        // Enable dropped mid-frame: frame aborted, buffered byte kept
        run_vector(v5a, 1'b0);
        p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
        @(posedge clk);
        fork
            drive(8'h81, 8, 0, 0, 6, 0, 0);
            begin
                repeat (20) @(posedge clk);
                #1 en = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("abort_busy", busy_o, 0);
                chk("abort_valid", rx_valid_o, 1);
                chk("abort_data", rx_data_o, 8'h5A);
            end
        join
        @(negedge clk); en = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("abort_data_kept", rx_data_o, 8'h5A);
        chk("abort_perr", n_perr - p0, 0);
        chk("abort_ferr", n_ferr - f0, 0);
        chk("abort_ovf", n_ovf - o0, 0);
        $display("tx abort data=%02h valid=%0d", rx_data_o, rx_valid_o);
        ready = 1'b1;
        @(negedge clk);

        // Randomized frames against the frame-level model
        for (int i = 0; i < 30; i++) begin
            int         rdiv, rn, rp;
            logic [1:0] rbits;
            bit         rpe, rs2, rflip, rlow;
            logic [7:0] rdata, exp_byte, m;
            int         exp_perr, exp_ferr;
            rdiv  = $urandom_range(3, 20);
            rbits = 2'($urandom_range(0, 3));
            rpe   = 1'($urandom_range(0, 1));
            rs2   = 1'($urandom_range(0, 1));
            rdata = 8'($urandom_range(0, 255));
            rflip = rpe && ($urandom_range(0, 3) == 0);
            rlow  = ($urandom_range(0, 5) == 0);
            rn    = 5 + int'(rbits);
            rp    = rdiv + 1;
            m        = 8'hFF >> (8 - rn);
            exp_byte = rdata & m;
            exp_ferr = rlow ? 1 : 0;
            exp_perr = (rflip && !rlow) ? 1 : 0;

            @(negedge clk);
            div = 16'(rdiv); bits = rbits; pe = rpe; s2 = rs2;
            got.delete();
            p0 = n_perr; f0 = n_ferr;
            @(posedge clk);
            drive(rdata, rn, rpe, rs2, rp, rflip, rlow);
            #1 line = 1'b1;
            repeat (3 * rp + 10) @(posedge clk);
            @(negedge clk);
            chk("rnd_count", got.size(), (rlow ? 0 : 1));
            if (got.size() > 0) chk("rnd_data", got[0], exp_byte);
            chk("rnd_perr", n_perr - p0, exp_perr);
            chk("rnd_ferr", n_ferr - f0, exp_ferr);
            $display("tx rnd %0d div=%0d n=%0d par=%0d stop2=%0d data=%02h flip=%0d low=%0d got=%0d",
                     i, rdiv, rn, rpe, rs2, rdata, rflip, rlow, got.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
